// File: rtl/acumulador_pkg.sv
// Shared types and helpers for the digit accumulator: FSM state encoding,
// error codes, ASCII landmarks and the ASCII digit decoder.
package acumulador_pkg;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_ACCUM  = 5'b00010,
    ST_DRAIN  = 5'b00100,
    ST_FINISH = 5'b01000,
    ST_DONE   = 5'b10000
  } estado_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CHAR = 2'd1;
  localparam logic [1:0] ERR_OVF  = 2'd2;
  localparam logic [1:0] ERR_LEN  = 2'd3;

  localparam logic [7:0] ASC_CERO  = 8'h30;
  localparam logic [7:0] ASC_A_MAY = 8'h41;
  localparam logic [7:0] ASC_A_MIN = 8'h61;
  localparam logic [7:0] ASC_MENOS = 8'h2D;

  // Returns {valid, value[4:0]}; radix range is checked by the caller.
  function automatic logic [5:0] ascii_to_digit(input logic [7:0] c);
    logic [5:0] r;
    r = 6'd0;
    if ((c >= ASC_CERO) && (c <= (ASC_CERO + 8'd9))) begin
      r = {1'b1, 5'(c - ASC_CERO)};
    end else if ((c >= ASC_A_MAY) && (c <= (ASC_A_MAY + 8'd5))) begin
      r = {1'b1, 5'(c - ASC_A_MAY + 8'd10)};
    end else if ((c >= ASC_A_MIN) && (c <= (ASC_A_MIN + 8'd5))) begin
      r = {1'b1, 5'(c - ASC_A_MIN + 8'd10)};
    end else begin
      r = 6'd0;
    end
    return r;
  endfunction

endpackage

// File: rtl/detector_flanco.sv
// Rising-edge detector: registers the input level and pulses for exactly one
// cycle when a high level is first sampled.
module detector_flanco (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic pulse
);

  logic sig_q_r;

  // Previous sampled level, updated every clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q_r <= 1'b0;
    end else begin
      sig_q_r <= sig;
    end
  end

  assign pulse = sig & ~sig_q_r;

endmodule

// File: rtl/acumulador_digitos.sv
// Folds a stream of digit bytes into a binary integer (acc = acc*RADIX + digit),
// with optional sign, and reports bad-character, overflow and length errors.
module acumulador_digitos
  import acumulador_pkg::*;
#(
  parameter int          DATA_W     = 8,
  parameter int          RES_W      = 32,
  parameter int unsigned RADIX      = 10,
  parameter int          MAX_DIGITS = 10,
  parameter int          ASCII_MODE = 1,
  parameter int          SIGNED_EN  = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DATA_W-1:0]                 dato,
  input  logic                              num_ready,
  input  logic                              fin,
  output logic [RES_W-1:0]                  resultado,
  output logic                              done,
  output logic                              err,
  output logic [1:0]                        err_code,
  output logic [$clog2(MAX_DIGITS+1)-1:0]   digit_count,
  output logic                              busy
);

  localparam int CW    = $clog2(MAX_DIGITS + 1);
  localparam int NXT_W = RES_W + 5;

  localparam logic [NXT_W-1:0] LIM_UNS = (NXT_W'(1'b1) << RES_W) - NXT_W'(1'b1);
  localparam logic [NXT_W-1:0] LIM_POS = (NXT_W'(1'b1) << (RES_W - 1)) - NXT_W'(1'b1);
  localparam logic [NXT_W-1:0] LIM_NEG = NXT_W'(1'b1) << (RES_W - 1);

  logic nr_ev_s;
  logic fin_ev_s;

  detector_flanco u_det_nr (
    .clk   (clk),
    .rst_n (reset),
    .sig   (num_ready),
    .pulse (nr_ev_s)
  );

  detector_flanco u_det_fin (
    .clk   (clk),
    .rst_n (reset),
    .sig   (fin),
    .pulse (fin_ev_s)
  );

  estado_t          state_r, state_n;
  logic [RES_W-1:0] acc_r, acc_n;
  logic             neg_r, neg_n;
  logic [CW-1:0]    cnt_r, cnt_n;
  logic [1:0]       code_r, code_n;
  logic [RES_W-1:0] resultado_r, res_n;
  logic             err_r, err_n;
  logic [1:0]       err_code_r, errc_n;
  logic             done_r, done_n;
  logic             busy_r, busy_n;

  logic [7:0]       byte_s;
  logic             hi_s;
  logic [5:0]       dec_s;
  logic [4:0]       dig_val_s;
  logic             dig_ok_s;
  logic             minus_s;
  logic [NXT_W-1:0] nxt_s;
  logic [NXT_W-1:0] lim_s;

  // Byte classification; upper bits beyond a byte make an ASCII char invalid.
  always_comb begin
    byte_s = 8'(dato);
    hi_s   = |(dato >> 8);
    dec_s  = ascii_to_digit(byte_s);
    if (ASCII_MODE != 0) begin
      dig_val_s = dec_s[4:0];
      dig_ok_s  = dec_s[5] & ~hi_s & (32'(dec_s[4:0]) < RADIX);
      minus_s   = (SIGNED_EN != 0) & ~hi_s & (byte_s == ASC_MENOS);
    end else begin
      dig_val_s = 5'(dato);
      dig_ok_s  = (32'(dato) < RADIX);
      minus_s   = 1'b0;
    end
  end

  // Candidate accumulator and the magnitude limit for the current sign.
  always_comb begin
    nxt_s = ({5'b00000, acc_r} * NXT_W'(RADIX)) + NXT_W'(dig_val_s);
    if (SIGNED_EN == 0) begin
      lim_s = LIM_UNS;
    end else if (neg_r) begin
      lim_s = LIM_NEG;
    end else begin
      lim_s = LIM_POS;
    end
  end

  // Next-state and datapath; a byte and fin on the same edge fold the byte first.
  always_comb begin
    state_n = state_r;
    acc_n   = acc_r;
    neg_n   = neg_r;
    cnt_n   = cnt_r;
    code_n  = code_r;
    res_n   = resultado_r;
    err_n   = err_r;
    errc_n  = err_code_r;
    done_n  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (nr_ev_s) begin
          if (dig_ok_s) begin
            acc_n   = RES_W'(dig_val_s);
            cnt_n   = CW'(1'b1);
            state_n = fin_ev_s ? ST_FINISH : ST_ACCUM;
          end else if (minus_s) begin
            neg_n = 1'b1;
            if (fin_ev_s) begin
              code_n  = ERR_CHAR;
              state_n = ST_FINISH;
            end else begin
              state_n = ST_ACCUM;
            end
          end else begin
            code_n  = ERR_CHAR;
            state_n = fin_ev_s ? ST_FINISH : ST_DRAIN;
          end
        end else if (fin_ev_s) begin
          state_n = ST_FINISH;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (nr_ev_s) begin
          if (!dig_ok_s) begin
            code_n  = ERR_CHAR;
            state_n = fin_ev_s ? ST_FINISH : ST_DRAIN;
          end else if (cnt_r == CW'(MAX_DIGITS)) begin
            code_n  = ERR_LEN;
            state_n = fin_ev_s ? ST_FINISH : ST_DRAIN;
          end else if (nxt_s > lim_s) begin
            code_n  = ERR_OVF;
            state_n = fin_ev_s ? ST_FINISH : ST_DRAIN;
          end else begin
            acc_n   = nxt_s[RES_W-1:0];
            cnt_n   = cnt_r + CW'(1'b1);
            state_n = fin_ev_s ? ST_FINISH : ST_ACCUM;
          end
        end else if (fin_ev_s) begin
          // Only a lone '-' can reach here with no digits.
          if (cnt_r == CW'(1'b0)) begin
            code_n = ERR_CHAR;
          end else begin
            code_n = code_r;
          end
          state_n = ST_FINISH;
        end else begin
          state_n = ST_ACCUM;
        end
      end
      ST_DRAIN: begin
        if (fin_ev_s) begin
          state_n = ST_FINISH;
        end else begin
          state_n = ST_DRAIN;
        end
      end
      ST_FINISH: begin
        if (code_r != ERR_NONE) begin
          res_n  = {RES_W{1'b0}};
          err_n  = 1'b1;
          errc_n = code_r;
        end else begin
          res_n  = neg_r ? (~acc_r + RES_W'(1'b1)) : acc_r;
          err_n  = 1'b0;
          errc_n = ERR_NONE;
        end
        done_n  = 1'b1;
        state_n = ST_DONE;
      end
      ST_DONE: begin
        acc_n   = {RES_W{1'b0}};
        neg_n   = 1'b0;
        cnt_n   = {CW{1'b0}};
        code_n  = ERR_NONE;
        state_n = ST_IDLE;
      end
      default: begin
        acc_n   = {RES_W{1'b0}};
        neg_n   = 1'b0;
        cnt_n   = {CW{1'b0}};
        code_n  = ERR_NONE;
        state_n = ST_IDLE;
      end
    endcase
    busy_n = (state_n == ST_ACCUM) || (state_n == ST_DRAIN) || (state_n == ST_FINISH);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      acc_r       <= {RES_W{1'b0}};
      neg_r       <= 1'b0;
      cnt_r       <= {CW{1'b0}};
      code_r      <= ERR_NONE;
      resultado_r <= {RES_W{1'b0}};
      err_r       <= 1'b0;
      err_code_r  <= ERR_NONE;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_n;
      acc_r       <= acc_n;
      neg_r       <= neg_n;
      cnt_r       <= cnt_n;
      code_r      <= code_n;
      resultado_r <= res_n;
      err_r       <= err_n;
      err_code_r  <= errc_n;
      done_r      <= done_n;
      busy_r      <= busy_n;
    end
  end

  assign resultado   = resultado_r;
  assign done        = done_r;
  assign err         = err_r;
  assign err_code    = err_code_r;
  assign digit_count = cnt_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_acumulador_digitos.sv
// Self-checking bench: a decimal and a hexadecimal instance see the same byte
// stream and are compared against a plain-arithmetic reference model.
module tb_acumulador_digitos;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  dato = 8'h00;
  logic        num_ready = 1'b0;
  logic        fin = 1'b0;

  logic [31:0] res_d, res_h;
  logic        done_d, done_h, err_d, err_h, busy_d, busy_h;
  logic [1:0]  code_d, code_h;
  logic [3:0]  cnt_d, cnt_h;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] stim_q[$];

  always #5 clk = ~clk;

  acumulador_digitos dut_d (
    .clk(clk), .reset(reset), .dato(dato), .num_ready(num_ready), .fin(fin),
    .resultado(res_d), .done(done_d), .err(err_d), .err_code(code_d),
    .digit_count(cnt_d), .busy(busy_d)
  );

  acumulador_digitos #(.RADIX(16)) dut_h (
    .clk(clk), .reset(reset), .dato(dato), .num_ready(num_ready), .fin(fin),
    .resultado(res_h), .done(done_h), .err(err_h), .err_code(code_h),
    .digit_count(cnt_h), .busy(busy_h)
  );

  function automatic int valor_digito(input logic [7:0] b);
    if (b >= 8'h30 && b <= 8'h39) return int'(b) - 48;
    if (b >= 8'h41 && b <= 8'h46) return int'(b) - 55;
    if (b >= 8'h61 && b <= 8'h66) return int'(b) - 87;
    return -1;
  endfunction

  // Reference: interpret the whole byte string as a signed 32-bit number.
  function automatic void modelo(input int radix, output logic [31:0] res,
                                 output logic e, output logic [1:0] code, output int ndig);
    longint acc = 0;
    longint lim;
    bit neg = 1'b0;
    int c = 0;
    int n = 0;
    int d;
    for (int i = 0; i < stim_q.size(); i++) begin
      if (c == 0) begin
        d = valor_digito(stim_q[i]);
        lim = neg ? 64'h80000000 : 64'h7FFFFFFF;
        if (i == 0 && stim_q[i] == 8'h2D) neg = 1'b1;
        else if (d < 0 || d >= radix) c = 1;
        else if (n == 10) c = 3;
        else if (acc * radix + d > lim) c = 2;
        else begin
          acc = acc * radix + d;
          n++;
        end
      end
    end
    if (c == 0 && neg && n == 0) c = 1;
    ndig = n;
    code = 2'(c);
    e = (c != 0);
    if (c != 0) res = 32'd0;
    else res = neg ? 32'(-acc) : 32'(acc);
  endfunction

  task automatic set_str(input string s);
    stim_q.delete();
    for (int i = 0; i < s.len(); i++) stim_q.push_back(s[i]);
  endtask

  // Sends stim_q, then fin (optionally on the same edge as the last byte), checks the result.
  task automatic run_num(input string name, input bit overlap);
    logic [31:0] er_d, er_h;
    logic ee_d, ee_h;
    logic [1:0] ec_d, ec_h;
    int nd_d, nd_h, n, hold, cyc;
    bit got;
    modelo(10, er_d, ee_d, ec_d, nd_d);
    modelo(16, er_h, ee_h, ec_h, nd_h);
    n = stim_q.size();
    if (n == 0) overlap = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!(overlap && i == n - 1)) begin
        dato = stim_q[i];
        num_ready = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        num_ready = 1'b0;
        @(negedge clk);
      end
    end
    if (!overlap) begin
      n_cmp++;
      if (cnt_d !== 4'(nd_d))
        $display("FAIL %s digit_count: got %0d expected %0d", name, cnt_d, nd_d);
      else n_cmp = n_cmp;
      if (cnt_d !== 4'(nd_d)) n_bad++;
      n_cmp++;
      if (busy_d !== (n > 0)) begin
        $display("FAIL %s busy: got %b expected %b", name, busy_d, (n > 0));
        n_bad++;
      end
    end else begin
      dato = stim_q[n-1];
      num_ready = 1'b1;
    end
    fin = 1'b1;
    hold = $urandom_range(1, 3);
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc >= hold) begin
        fin = 1'b0;
        num_ready = 1'b0;
      end
      if (done_d === 1'b1) got = 1'b1;
    end
    n_cmp++;
    if (!got || cyc != 2) begin
      $display("FAIL %s done latency: got %0d cycles (seen=%b) expected 2", name, cyc, got);
      n_bad++;
    end
    n_cmp++;
    if (res_d !== er_d || err_d !== ee_d || code_d !== ec_d) begin
      $display("FAIL %s dec result: got %h/%b/%0d expected %h/%b/%0d",
               name, res_d, err_d, code_d, er_d, ee_d, ec_d);
      n_bad++;
    end
    n_cmp++;
    if (done_h !== 1'b1 || res_h !== er_h || err_h !== ee_h || code_h !== ec_h) begin
      $display("FAIL %s hex result: got done=%b %h/%b/%0d expected done=1 %h/%b/%0d",
               name, done_h, res_h, err_h, code_h, er_h, ee_h, ec_h);
      n_bad++;
    end
    @(negedge clk);
    fin = 1'b0;
    num_ready = 1'b0;
    n_cmp++;
    if (done_d !== 1'b0 || busy_d !== 1'b0 || res_d !== er_d || err_d !== ee_d) begin
      $display("FAIL %s after done: got done=%b busy=%b res=%h err=%b expected 0/0/%h/%b",
               name, done_d, busy_d, res_d, err_d, er_d, ee_d);
      n_bad++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (res_d !== 32'd0 || done_d !== 1'b0 || err_d !== 1'b0 || code_d !== 2'd0 ||
        cnt_d !== 4'd0 || busy_d !== 1'b0) begin
      $display("FAIL reset dec: got res=%h done=%b err=%b code=%0d cnt=%0d busy=%b expected all 0",
               res_d, done_d, err_d, code_d, cnt_d, busy_d);
      n_bad++;
    end
    n_cmp++;
    if (res_h !== 32'd0 || done_h !== 1'b0 || busy_h !== 1'b0) begin
      $display("FAIL reset hex: got res=%h done=%b busy=%b expected 0", res_h, done_h, busy_h);
      n_bad++;
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    set_str("123");
    run_num("basic_123", 1'b0);
    n_cmp++;
    if (res_d !== 32'd123) begin
      $display("FAIL basic_const: got %0d expected 123", res_d);
      n_bad++;
    end
  endtask

  task automatic test_signed();
    set_str("-42");
    run_num("neg_42", 1'b0);
    n_cmp++;
    if (res_d !== 32'hFFFFFFD6) begin
      $display("FAIL neg_const: got %h expected FFFFFFD6", res_d);
      n_bad++;
    end
    set_str("7");
    run_num("after_neg_7", 1'b0);
  endtask

  task automatic test_limits();
    set_str("2147483647"); run_num("max_pos", 1'b0);
    set_str("2147483648"); run_num("ovf_pos", 1'b0);
    n_cmp++;
    if (code_d !== 2'd2 || err_d !== 1'b1) begin
      $display("FAIL ovf_const: got code=%0d err=%b expected 2/1", code_d, err_d);
      n_bad++;
    end
    set_str("-2147483648"); run_num("max_neg", 1'b0);
    n_cmp++;
    if (res_d !== 32'h80000000) begin
      $display("FAIL max_neg_const: got %h expected 80000000", res_d);
      n_bad++;
    end
  endtask

  task automatic test_errors();
    set_str("1x5"); run_num("bad_char", 1'b0);
    set_str("12345678901"); run_num("too_long", 1'b0);
    n_cmp++;
    if (code_d !== 2'd3) begin
      $display("FAIL too_long_const: got code=%0d expected 3", code_d);
      n_bad++;
    end
    set_str("-"); run_num("lone_minus", 1'b0);
    set_str("4-2"); run_num("late_minus", 1'b0);
  endtask

  task automatic test_hex();
    set_str("Ff0"); run_num("hex_ff0", 1'b0);
    n_cmp++;
    if (res_h !== 32'h00000FF0) begin
      $display("FAIL hex_const: got %h expected 00000FF0", res_h);
      n_bad++;
    end
    set_str("A"); run_num("a_in_dec", 1'b0);
  endtask

  task automatic test_back_to_back();
    set_str(""); run_num("empty", 1'b0);
    set_str("89"); run_num("overlap_89", 1'b1);
    n_cmp++;
    if (res_d !== 32'd89) begin
      $display("FAIL overlap_const: got %0d expected 89", res_d);
      n_bad++;
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    set_str("55");
    for (int i = 0; i < 2; i++) begin
      dato = stim_q[i];
      num_ready = 1'b1;
      @(negedge clk);
      num_ready = 1'b0;
      @(negedge clk);
    end
    reset = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done_d === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (seen || cnt_d !== 4'd0 || res_d !== 32'd0 || busy_d !== 1'b0) begin
      $display("FAIL reset_mid: got done_seen=%b cnt=%0d res=%h busy=%b expected 0", seen, cnt_d, res_d, busy_d);
      n_bad++;
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    set_str("3"); run_num("after_reset_3", 1'b0);
  endtask

  task automatic test_random();
    int len, r;
    for (int k = 0; k < 40; k++) begin
      stim_q.delete();
      len = $urandom_range(0, 12);
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 24);
        if (r < 10) stim_q.push_back(8'h30 + 8'(r));
        else if (r < 14) stim_q.push_back(8'h41 + 8'($urandom_range(0, 5)));
        else if (r < 16) stim_q.push_back(8'h61 + 8'($urandom_range(0, 5)));
        else if (r == 16) stim_q.push_back(8'h2D);
        else if (r == 17) stim_q.push_back(8'h78);
        else stim_q.push_back(8'h30 + 8'($urandom_range(0, 9)));
      end
      if ($urandom_range(0, 3) == 0 && len > 0) stim_q[0] = 8'h2D;
      run_num($sformatf("random_%0d", k), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_limits();
    test_errors();
    test_hex();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/acumulador_digitos.md
Name: acumulador_digitos

Overview:
Parametrised successor to the UART number concatenator: converts a stream of received digit bytes into a binary integer.
- Each byte is folded in as it arrives: acc = acc*RADIX + digit. No FIFO, no post-processing pass.
- Adds: selectable radix, ASCII or raw digit input, optional leading '-', overflow, bad-character and digit-count error reporting.
- Sits between the UART RX byte interface and the ALU/TX side.

Parameters:
DATA_W, 8, width of dato.
RES_W, 32, width of resultado (two's complement when SIGNED_EN=1).
RADIX, 10, numeric base; legal range 2..16.
MAX_DIGITS, 10, maximum accepted digits per number.
ASCII_MODE, 1, 1: dato is ASCII ('0'-'9', 'A'-'F', 'a'-'f'); 0: dato is the raw digit value.
SIGNED_EN, 1, 1: '-' (8'h2D) accepted as the first byte in ASCII_MODE.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
dato  in  DATA_W  received byte; valid while num_ready is high.
num_ready  in  1  byte strobe, level; may stay high for many cycles; one byte per rising edge.
fin  in  1  end-of-number strobe, level; one event per rising edge.
resultado  out  RES_W  final value; held until the next done.
done  out  1  one-cycle pulse; resultado and err are valid in that cycle.
err  out  1  number rejected (resultado forced to 0); held like resultado.
err_code  out  2  0 none, 1 bad char, 2 overflow, 3 too many digits.
digit_count  out  $clog2(MAX_DIGITS+1)  digits accepted so far.
busy  out  1  high in ACCUM, DRAIN and FINISH.

Behaviour:
- Reset (async, low) clears everything:
  - Outputs: resultado=0, done=0, err=0, err_code=0, digit_count=0, busy=0.
  - Internal: acc=0, neg=0, edge registers=0, state=IDLE.
  - Reset mid-number discards the partial number. No done is emitted.
- Edge detection:
  - nr_ev = num_ready & ~num_ready_q; fin_ev = fin & ~fin_q.
  - The _q registers are updated every clk.
  - A level held high produces exactly one event.
- States, one-hot 5 bits: IDLE, ACCUM, DRAIN, FINISH, DONE.
  - IDLE, nr_ev:
    - Valid digit: acc=digit, digit_count=1, go to ACCUM.
    - '-' with SIGNED_EN: neg=1, go to ACCUM.
    - Anything else: latch err_code=1, go to DRAIN.
  - IDLE, fin_ev with no digits: go to FINISH; the result is 0 with err=0.
  - ACCUM, nr_ev:
    - Compute nxt = acc*RADIX + digit in RES_W+5 bits.
    - Bad char (non-digit, digit>=RADIX, or '-' after the first byte): code 1, go to DRAIN.
    - digit_count==MAX_DIGITS: code 3, go to DRAIN.
    - nxt > LIMIT: code 2, go to DRAIN.
    - Otherwise acc<=nxt[RES_W-1:0] and digit_count increments.
  - LIMIT values:
    - SIGNED_EN=0: 2^RES_W-1.
    - SIGNED_EN=1 and neg=0: 2^(RES_W-1)-1.
    - SIGNED_EN=1 and neg=1: 2^(RES_W-1).
  - ACCUM, fin_ev: go to FINISH.
    - A lone '-' with no digit is a bad char (code 1).
  - DRAIN: ignores nr_ev and keeps the first error code only. fin_ev goes to FINISH.
  - FINISH (1 cycle):
    - Without error: resultado <= neg ? -acc : acc.
    - With error: resultado<=0, err<=1.
    - Then go to DONE.
  - DONE (1 cycle): done=1, clear acc/neg/digit_count/err latch, go to IDLE.
- Timing:
  - First edge sampling fin high = E1; state=FINISH after E1.
  - resultado, err and done=1 are registered at E2; done drops at E3.
  - Next number accepted from E3.
  - A digit whose num_ready is first sampled at edge E is folded in at E.
- Simultaneous nr_ev and fin_ev in IDLE/ACCUM: the byte is processed first, including error checks, then FINISH. The byte is part of the number.
- nr_ev or fin_ev arriving in FINISH/DONE is dropped; the _q registers still track it, so no late event occurs.
- ASCII_MODE=0: dato is used directly as the digit value; '-' is not recognised.

Decomposition:
- Package acumulador_pkg:
  - One-hot state constants.
  - ERR_NONE/ERR_CHAR/ERR_OVF/ERR_LEN.
  - ASCII constants ('0', 'A', 'a', '-').
  - Function ascii_to_digit returning {valid, value[4:0]}.
- Sub-module detector_flanco, instantiated for num_ready and fin:
  - Async active-low reset.
  - Registered input.
  - Single-cycle rise pulse.

Test Plan:
1. Defaults; send '1','2','3' (num_ready held 3 cycles each), then fin -> done pulse 2 edges after fin; resultado=123, err=0.
2. '-','4','2', fin -> resultado=-42 (32'hFFFFFFD6), err=0; then '7', fin -> resultado=7 (neg cleared).
3. "2147483647" -> resultado=2147483647. "2147483648" -> err=1, err_code=2, resultado=0. "-2147483648" -> 32'h80000000, err=0.
4. '1','x','5', fin -> err_code=1, resultado=0; bytes after 'x' ignored. 11 digits -> err_code=3.
5. RADIX=16: 'F','f','0', fin -> resultado=16'hFF0 zero-extended. With RADIX=10, 'A' -> err_code=1.
6. fin with no digits -> done, resultado=0, err=0. num_ready and fin rising on the same edge with '9' after "8" -> resultado=89. Reset low after "55" -> no done; next "3" -> 3.
